bsg_fifo_1rw_large_sched: RTL and testbench

//  Scheduler for the single-port (1rw) backing RAM of a large FIFO. Each cycle it grants at

---
 rtl/bsg_fifo_1rw_large_sched.sv | 116 +++++++++++
 tb/tb_bsg_fifo_1rw_large_sched.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_1rw_large_sched.sv
// Scheduler for the single-port backing RAM of a large FIFO: grants one write (spill) or read (refill) per cycle.
// Latency: grant is combinational; deq_v_o follows a read grant by one cycle; count/full/empty update next cycle.
// Backpressure: writes stall when full; reads stall when empty or out of downstream credits.
module bsg_fifo_1rw_large_sched #(
  parameter  int els_p     = 16,
  parameter  int credits_p = 2,
  localparam int lg_els_lp = $clog2(els_p),
  localparam int lg_cnt_lp = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enq_v_i,
  output logic                 enq_yumi_o,
  input  logic                 deq_urgent_i,
  input  logic                 credit_i,
  output logic                 mem_v_o,
  output logic                 mem_w_o,
  output logic [lg_els_lp-1:0] mem_addr_o,
  output logic                 deq_v_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [lg_cnt_lp-1:0] count_o
);

  localparam int lg_cred_lp = $clog2(credits_p + 1);

  logic [lg_els_lp-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [lg_cnt_lp-1:0]  count_q, count_d;
  logic [lg_cred_lp-1:0] credits_q, credits_d;
  logic [lg_cred_lp:0]   cred_sum;
  logic                  prio_q, prio_d;
  logic                  deq_v_q;
  logic                  full, empty, enq_ok, deq_ok;
  logic                  wr_grant, rd_grant;

  assign full  = (count_q == lg_cnt_lp'(els_p));
  assign empty = (count_q == '0);

  // Nothing is granted while reset is asserted, so a read in the reset cycle never produces deq_v_o.
  assign enq_ok = enq_v_i & ~full & ~reset_i;
  assign deq_ok = ~empty & (credits_q != '0) & ~reset_i;

  // Arbitrate the single RAM port; round-robin priority flips only when both sides compete.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    prio_d   = prio_q;
    if (enq_ok && deq_ok) begin
      if (deq_urgent_i || prio_q) begin
        rd_grant = 1'b1;
        prio_d   = 1'b0;
      end else begin
        wr_grant = 1'b1;
        prio_d   = 1'b1;
      end
    end else begin
      wr_grant = enq_ok;
      rd_grant = deq_ok;
    end
  end

  assign mem_v_o    = wr_grant | rd_grant;
  assign mem_w_o    = wr_grant;
  assign mem_addr_o = wr_grant ? wptr_q : (rd_grant ? rptr_q : '0);
  assign enq_yumi_o = wr_grant;

  // Pointer, occupancy and credit next-state; pointers wrap at els_p so non-power-of-two depths work.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_grant) begin
      wptr_d  = (wptr_q == lg_els_lp'(els_p - 1)) ? '0 : wptr_q + lg_els_lp'(1);
      count_d = count_q + lg_cnt_lp'(1);
    end else if (rd_grant) begin
      rptr_d  = (rptr_q == lg_els_lp'(els_p - 1)) ? '0 : rptr_q + lg_els_lp'(1);
      count_d = count_q - lg_cnt_lp'(1);
    end
    // A read grant implies credits_q >= 1, so the subtraction never underflows.
    cred_sum  = {1'b0, credits_q} - (lg_cred_lp + 1)'(rd_grant) + (lg_cred_lp + 1)'(credit_i);
    credits_d = (cred_sum > (lg_cred_lp + 1)'(credits_p)) ? lg_cred_lp'(credits_p)
                                                          : cred_sum[lg_cred_lp-1:0];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      credits_q <= lg_cred_lp'(credits_p);
      prio_q    <= 1'b0;
      deq_v_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
      prio_q    <= prio_d;
      deq_v_q   <= rd_grant;
    end
  end

  // Downstream must never return more slots than it was given.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      credit_overflow: assert (!(credit_i && (credits_q == lg_cred_lp'(credits_p))));
    end
  end

  assign deq_v_o = deq_v_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = count_q;

endmodule

// File: tb/tb_bsg_fifo_1rw_large_sched.sv
// Bench for the 1rw large-FIFO scheduler: a 16-deep and a 5-deep instance share stimulus.
// Expected grants are given per cycle; expected deq_v pulses are queued and checked a cycle later.
// The inactive instance is held in reset and sees no enq/credit traffic.
module tb_bsg_fifo_1rw_large_sched;

  logic clk, reset, enq, urg, credit, sel;

  logic       m16_v, m16_w, y16, d16, f16, e16;
  logic [3:0] a16;
  logic [4:0] c16;
  logic       m5_v, m5_w, y5, d5, f5, e5;
  logic [2:0] a5;
  logic [2:0] c5;

  int vectors = 0;
  int miscompares = 0;
  bit dq[$];

  bsg_fifo_1rw_large_sched #(.els_p(16), .credits_p(2)) dut (
    .clk_i(clk), .reset_i(reset | sel), .enq_v_i(enq & ~sel), .enq_yumi_o(y16),
    .deq_urgent_i(urg), .credit_i(credit & ~sel), .mem_v_o(m16_v), .mem_w_o(m16_w),
    .mem_addr_o(a16), .deq_v_o(d16), .full_o(f16), .empty_o(e16), .count_o(c16)
  );

  bsg_fifo_1rw_large_sched #(.els_p(5), .credits_p(2)) dut5 (
    .clk_i(clk), .reset_i(reset | ~sel), .enq_v_i(enq & sel), .enq_yumi_o(y5),
    .deq_urgent_i(urg), .credit_i(credit & sel), .mem_v_o(m5_v), .mem_w_o(m5_w),
    .mem_addr_o(a5), .deq_v_o(d5), .full_o(f5), .empty_o(e5), .count_o(c5)
  );

  logic o_v, o_w, o_y, o_d, o_f, o_e;
  int   o_a, o_c;
  assign o_v = sel ? m5_v : m16_v;
  assign o_w = sel ? m5_w : m16_w;
  assign o_y = sel ? y5 : y16;
  assign o_d = sel ? d5 : d16;
  assign o_f = sel ? f5 : f16;
  assign o_e = sel ? e5 : e16;
  assign o_a = sel ? int'(a5) : int'(a16);
  assign o_c = sel ? int'(c5) : int'(c16);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One cycle: apply inputs, check this cycle's grant and last cycle's deq_v, queue this cycle's deq_v.
  task automatic drive(input bit e, input bit u, input bit c,
                       input bit xv, input bit xw, input int xa, input string tag);
    bit xd;
    enq = e; urg = u; credit = c;
    @(negedge clk);
    chk({tag, ".mem_v"}, o_v, xv);
    if (xv) begin
      chk({tag, ".mem_w"}, o_w, xw);
      chk({tag, ".addr"}, o_a, xa);
    end
    chk({tag, ".yumi"}, o_y, xv & xw);
    xd = (dq.size() != 0) ? dq.pop_front() : 1'b0;
    chk({tag, ".deq_v"}, o_d, xd);
    dq.push_back(xv & ~xw);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit e);
    reset = 1'b1; enq = e; urg = 1'b0; credit = 1'b0;
    @(negedge clk);
    chk("rst.mem_v", o_v, 0);
    chk("rst.yumi", o_y, 0);
    @(posedge clk); #1;
    reset = 1'b0; enq = 1'b0;
    dq.delete();
    dq.push_back(1'b0);
    chk("rst.count", o_c, 0);
    chk("rst.empty", o_e, 1);
    chk("rst.full", o_f, 0);
  endtask

  initial begin
    reset = 1'b1; enq = 1'b0; urg = 1'b0; credit = 1'b0; sel = 1'b0;
    do_reset(1'b1);

    // Conflict alternation: W, W, then R/W alternate while both are eligible.
    drive(1, 0, 0, 1, 1, 0, "w0");
    drive(1, 0, 0, 1, 1, 1, "w1");
    drive(1, 0, 0, 1, 0, 0, "r0");
    drive(1, 0, 0, 1, 1, 2, "w2");
    drive(1, 0, 0, 1, 0, 1, "r1");
    chk("alt.count", o_c, 1);

    // Credits exhausted: fill to full with wrapping write pointer.
    for (int i = 0; i < 15; i++) drive(1, 0, 0, 1, 1, (3 + i) % 16, "fill");
    chk("fill.full", o_f, 1);
    chk("fill.count", o_c, 16);
    chk("fill.empty", o_e, 0);
    drive(1, 0, 0, 0, 0, 0, "ovf");
    drive(1, 0, 1, 0, 0, 0, "crd");
    drive(1, 0, 0, 1, 0, 2, "rfull");
    chk("rfull.count", o_c, 15);
    chk("rfull.full", o_f, 0);
    drive(1, 0, 0, 1, 1, 2, "refill");
    chk("refill.count", o_c, 16);

    // Credit handling: read+credit keeps credits, back-to-back reads, stall, resume.
    drive(0, 0, 1, 0, 0, 0, "cA");
    drive(0, 0, 1, 1, 0, 3, "cB");
    drive(0, 0, 0, 1, 0, 4, "cC");
    drive(0, 0, 0, 0, 0, 0, "stall");
    drive(0, 0, 1, 0, 0, 0, "cE");
    drive(0, 0, 0, 1, 0, 5, "cF");
    chk("cred.count", o_c, 13);

    // Urgent: reads win every conflict until credits run out.
    drive(0, 0, 1, 0, 0, 0, "uG");
    drive(1, 1, 1, 1, 0, 6, "uH");
    drive(1, 1, 0, 1, 0, 7, "uI");
    drive(1, 1, 0, 1, 1, 3, "uJ");
    chk("urg.count", o_c, 12);

    // Reset during streaming reads.
    drive(0, 0, 1, 0, 0, 0, "sK");
    drive(0, 0, 1, 1, 0, 8, "sL");
    do_reset(1'b1);
    drive(1, 0, 0, 1, 1, 0, "post");
    chk("post.count", o_c, 1);

    // Wrap on the 5-deep instance: 7 writes interleaved with 7 reads.
    sel = 1'b1;
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, (i > 0), 1, 1, i % 5, "wrapw");
      drive(0, 0, 0, 1, 0, i % 5, "wrapr");
    end
    drive(0, 0, 0, 0, 0, 0, "wrapidle");
    chk("wrap.empty", o_e, 1);
    chk("wrap.count", o_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
